hazard_scoreboard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 16 +
 rtl/wb_scoreboard.sv | 72 +++++++
 rtl/hazard_scoreboard_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and sizing for the hazard scoreboard controller

package hazard_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = 5;
   localparam int CNT_W     = 2;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } ctrl_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register in-flight write counters with issue/writeback ports

module wb_scoreboard #(
   parameter int NUM_REGS = hazard_pkg::NUM_REGS,
   parameter int CNT_W    = hazard_pkg::CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 inc_en_i,
   input  hazard_pkg::reg_idx_t inc_idx_i,
   input  logic                 dec_en_i,
   input  hazard_pkg::reg_idx_t dec_idx_i,
   output logic [NUM_REGS-1:0]  busy_o,
   output logic                 err_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] inc_sel;
   logic [NUM_REGS-1:0] dec_sel;
   logic [NUM_REGS-1:0] ovf;
   logic [NUM_REGS-1:0] unf;

   // one-hot select of the issuing and retiring register; x0 is never tracked
   always_comb begin
      inc_sel = '0;
      dec_sel = '0;
      if (inc_en_i) inc_sel[inc_idx_i] = 1'b1;
      if (dec_en_i) dec_sel[dec_idx_i] = 1'b1;
      inc_sel[0] = 1'b0;
      dec_sel[0] = 1'b0;
   end

   // next count per register; a simultaneous inc and dec on one register cancel out,
   // and a saturating or underflowing update holds the counter and flags an error
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
         ovf[i]   = 1'b0;
         unf[i]   = 1'b0;
         if (inc_sel[i] && !dec_sel[i]) begin
            if (cnt_q[i] == CNT_MAX) ovf[i] = 1'b1;
            else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (dec_sel[i] && !inc_sel[i]) begin
            if (cnt_q[i] == '0) unf[i] = 1'b1;
            else                unf[i] = 1'b0;
            if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
         end
      end
   end

   // busy flags read by the hazard compare, and the single-cycle error pulse
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_o[i] = (cnt_q[i] != '0);
      end
      err_o = (|ovf) | (|unf);
   end

   // counter storage; reset discards every in-flight write
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - RAW stall and redirect flush controller for the 5-stage pipeline

module hazard_scoreboard_ctrl #(
   parameter int NUM_REGS        = hazard_pkg::NUM_REGS,
   parameter int CNT_W           = hazard_pkg::CNT_W,
   parameter int REDIRECT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  hazard_pkg::reg_idx_t id_rs1,
   input  logic                 id_rs1_used,
   input  hazard_pkg::reg_idx_t id_rs2,
   input  logic                 id_rs2_used,
   input  hazard_pkg::reg_idx_t id_rd,
   input  logic                 id_rd_wren,
   input  hazard_pkg::reg_idx_t wb_rd,
   input  logic                 wb_rd_wren,
   input  logic                 ex_redirect,
   output logic                 issue,
   output logic                 stall_if,
   output logic                 bubble_idex,
   output logic                 flush_ifid,
   output logic                 sb_err
);

   import hazard_pkg::*;

   // number of extra IF/ID flush cycles loaded on every redirect
   localparam logic [1:0] FLUSH_LOAD = 2'(REDIRECT_CYCLES);

   logic [NUM_REGS-1:0] busy;
   logic                sb_pulse;
   logic                rs1_hz;
   logic                rs2_hz;
   logic                hz;
   logic                inc_en;
   logic                dec_en;
   ctrl_state_t         state_q;
   ctrl_state_t         state_d;
   logic [1:0]          fcnt_q;
   logic [1:0]          fcnt_d;
   logic                sb_err_q;
   logic                sb_err_d;

   // RAW check: a source is blocked while any write to it is still in flight;
   // a same-cycle writeback does not unblock because the register file lands next edge
   always_comb begin
      rs1_hz = id_rs1_used && (id_rs1 != '0) && busy[id_rs1];
      rs2_hz = id_rs2_used && (id_rs2 != '0) && busy[id_rs2];
      hz     = id_valid && (rs1_hz || rs2_hz);
   end

   // pipeline control outputs; a redirect kills the wrong-path ID instruction
   always_comb begin
      issue       = 1'b0;
      stall_if    = 1'b0;
      bubble_idex = 1'b1;
      flush_ifid  = 1'b1;
      if (state_q == RUN) begin
         issue       = id_valid && !hz && !ex_redirect;
         stall_if    = hz && !ex_redirect;
         bubble_idex = !(id_valid && !hz && !ex_redirect);
         flush_ifid  = ex_redirect;
      end
   end

   // redirect sequencing: FLUSH holds IF/ID cleared while the IMEM refetch is in flight
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         RUN: begin
            if (ex_redirect && (FLUSH_LOAD != 2'd0)) begin
               state_d = FLUSH;
               fcnt_d  = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            if (ex_redirect) begin
               fcnt_d = FLUSH_LOAD;
            end else if (fcnt_q <= 2'd1) begin
               state_d = RUN;
               fcnt_d  = 2'd0;
            end else begin
               fcnt_d = fcnt_q - 2'd1;
            end
         end
         default: begin
            state_d = RUN;
            fcnt_d  = 2'd0;
         end
      endcase
   end

   // scoreboard update requests from issue and writeback; x0 writes are ignored
   always_comb begin
      inc_en   = issue && id_rd_wren && (id_rd != '0);
      dec_en   = wb_rd_wren && (wb_rd != '0);
      sb_err_d = sb_err_q | sb_pulse;
   end

   // FSM, flush counter and sticky error state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         fcnt_q   <= 2'd0;
         sb_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         sb_err_q <= sb_err_d;
      end
   end

   assign sb_err = sb_err_q;

   wb_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .CNT_W    (CNT_W)
   ) u_sb (
      .clk_i     (clk),
      .rst_ni    (rst),
      .inc_en_i  (inc_en),
      .inc_idx_i (id_rd),
      .dec_en_i  (dec_en),
      .dec_idx_i (wb_rd),
      .busy_o    (busy),
      .err_o     (sb_pulse)
   );

endmodule
